// File: rtl/segment_seq.sv
// Frame sequencer for the digit-segmentation datapath: clear, accumulate, scan, present.
// Optional SEG_AUTO_ACK_EN: result is a one-cycle res_valid_o pulse and res_ready_i is ignored.
module segment_seq #(
    parameter int unsigned SEG_W    = 75,
    parameter int unsigned SEG_HALF = 37,
    parameter int unsigned VTOP     = 150,
    parameter int unsigned VMID     = 225,
    parameter int unsigned VBOT     = 300,
    parameter int unsigned THRESH   = 75
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [9:0]  hcnt_i,
    input  logic [9:0]  vcnt_i,
    output logic        acc_clr_o,
    output logic        acc_en_o,
    output logic [2:0]  acc_seg_o,
    output logic [1:0]  acc_quad_o,
    output logic [4:0]  rd_sel_o,
    input  logic [13:0] rd_sum_i,
    output logic [23:0] res_pattern_o,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic        busy_o,
    output logic        overrun_o
);

    localparam int unsigned NSEG = 6;

    localparam logic [10:0] SegW    = 11'(SEG_W);
    localparam logic [10:0] SegHalf = 11'(SEG_HALF);
    localparam logic [9:0]  VTopV   = 10'(VTOP);
    localparam logic [9:0]  VMidV   = 10'(VMID);
    localparam logic [9:0]  VBotV   = 10'(VBOT);
    localparam logic [13:0] ThreshV = 14'(THRESH);
    localparam logic [4:0]  LastIdx = 5'd23;
    localparam logic [4:0]  ScanEnd = 5'd24;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StScan,
        StPresent
    } state_e;

    function automatic logic [10:0] seg_x0(input int unsigned s);
        case (s)
            0:       seg_x0 = 11'd50;
            1:       seg_x0 = 11'd140;
            2:       seg_x0 = 11'd230;
            3:       seg_x0 = 11'd335;
            4:       seg_x0 = 11'd425;
            default: seg_x0 = 11'd515;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] scan_q, scan_d;
    logic [23:0] pat_q, pat_d;
    logic        ovr_q, ovr_d;
    logic        en_q, en_d;
    logic [2:0]  seg_q, seg_d;
    logic [1:0]  quad_q, quad_d;

    logic        fs;
    logic [10:0] hx;
    logic        in_win;
    logic        lower;
    logic        past_bot;
    logic        sum_on;
    logic        hit;
    logic [2:0]  hit_seg;
    logic        hit_right;

    assign fs       = (hcnt_i == 10'd0) && (vcnt_i == 10'd0);
    assign hx       = {1'b0, hcnt_i};
    assign in_win   = (vcnt_i > VTopV) && (vcnt_i <= VBotV);
    assign lower    = vcnt_i > VMidV;
    assign past_bot = vcnt_i > VBotV;
    assign sum_on   = rd_sum_i >= ThreshV;

    // Spans are disjoint, so at most one segment matches.
    always_comb begin
        hit       = 1'b0;
        hit_seg   = 3'd0;
        hit_right = 1'b0;
        for (int unsigned s = 0; s < NSEG; s++) begin
            if ((hx > seg_x0(s)) && (hx < seg_x0(s) + SegW)) begin
                hit       = 1'b1;
                hit_seg   = 3'(s);
                hit_right = hx > (seg_x0(s) + SegHalf);
            end
        end
    end

`ifdef SEG_AUTO_ACK_EN
    logic unused_ready;
    assign unused_ready = res_ready_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scan_d  = scan_q;
        pat_d   = pat_q;
        ovr_d   = 1'b0;
        en_d    = 1'b0;
        seg_d   = seg_q;
        quad_d  = quad_q;

        unique case (state_q)
            StIdle: begin
                if (fs) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StAccum;
            end
            StAccum: begin
                if (fs) begin
                    ovr_d   = 1'b1;
                    state_d = StClear;
                end else if (past_bot) begin
                    cnt_d   = 5'd0;
                    state_d = StScan;
                end else if (in_win && hit) begin
                    en_d   = 1'b1;
                    seg_d  = hit_seg;
                    quad_d = {lower, hit_right};
                end
            end
            StScan: begin
                if (fs) begin
                    // Partial scan is dropped; the committed pattern is untouched.
                    ovr_d   = 1'b1;
                    state_d = StClear;
                end else begin
                    if (cnt_q != 5'd0) begin
                        scan_d[cnt_q - 5'd1] = sum_on;
                    end
                    if (cnt_q == ScanEnd) begin
                        pat_d   = scan_d;
                        state_d = StPresent;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StPresent: begin
`ifdef SEG_AUTO_ACK_EN
                state_d = fs ? StClear : StIdle;
`else
                // A frame start coinciding with the transfer is not lost.
                if (res_ready_i) begin
                    state_d = fs ? StClear : StIdle;
                end else if (fs) begin
                    ovr_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            scan_q  <= 24'd0;
            pat_q   <= 24'd0;
            ovr_q   <= 1'b0;
            en_q    <= 1'b0;
            seg_q   <= 3'd0;
            quad_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            pat_q   <= pat_d;
            ovr_q   <= ovr_d;
            en_q    <= en_d;
            seg_q   <= seg_d;
            quad_q  <= quad_d;
        end
    end

    assign acc_clr_o     = state_q == StClear;
    assign acc_en_o      = en_q;
    assign acc_seg_o     = seg_q;
    assign acc_quad_o    = quad_q;
    assign rd_sel_o      = ((state_q == StScan) && (cnt_q <= LastIdx)) ? cnt_q : 5'd0;
    assign res_pattern_o = pat_q;
    assign res_valid_o   = state_q == StPresent;
    assign busy_o        = (state_q == StClear) || (state_q == StAccum) || (state_q == StScan);
    assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_segment_seq.sv
// Scoreboard bench for segment_seq: decode sweep, readback scan, handshake and overrun cases.
// Honours SEG_AUTO_ACK_EN when the build defines it.
module tb_segment_seq;

    logic        clk_i;
    logic        rst_i;
    logic [9:0]  hcnt_i;
    logic [9:0]  vcnt_i;
    logic        acc_clr_o;
    logic        acc_en_o;
    logic [2:0]  acc_seg_o;
    logic [1:0]  acc_quad_o;
    logic [4:0]  rd_sel_o;
    logic [13:0] rd_sum_i;
    logic [23:0] res_pattern_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic        busy_o;
    logic        overrun_o;

    segment_seq dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .hcnt_i       (hcnt_i),
        .vcnt_i       (vcnt_i),
        .acc_clr_o    (acc_clr_o),
        .acc_en_o     (acc_en_o),
        .acc_seg_o    (acc_seg_o),
        .acc_quad_o   (acc_quad_o),
        .rd_sel_o     (rd_sel_o),
        .rd_sum_i     (rd_sum_i),
        .res_pattern_o(res_pattern_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Readback model: sum for rd_sel appears one cycle later.
    logic pat_mode;
    always_ff @(posedge clk_i) begin
        if (pat_mode) rd_sum_i <= (rd_sel_o < 5'd12) ? 14'h3fff : 14'd0;
        else          rd_sum_i <= rd_sel_o[0] ? 14'd74 : 14'd75;
    end

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_depth", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic step(input int h, input int v);
        @(negedge clk_i);
        hcnt_i = 10'(h);
        vcnt_i = 10'(v);
    endtask

    function automatic logic [31:0] acc_vec();
        return 32'({acc_en_o, acc_seg_o, acc_quad_o});
    endfunction

    function automatic logic [31:0] ctl_vec();
        return 32'({acc_clr_o, acc_en_o, acc_seg_o, acc_quad_o, rd_sel_o,
                    res_valid_o, busy_o, overrun_o});
    endfunction

    // Caller has just driven the first line past the window; returns at the first res_valid cycle.
    task automatic run_scan(input logic [23:0] exp_pat);
        int cyc;
        sb_push("scan_pattern", 32'(exp_pat));
        step(7, 302);
        check("scan_en_off", 32'(acc_en_o), 32'd0);
        check("scan_busy", 32'(busy_o), 32'd1);
        cyc = 0;
        while (res_valid_o !== 1'b1 && cyc < 100) begin
            if (cyc == 10) check("scan_rd_sel", 32'(rd_sel_o), 32'd10);
            step(7, 302);
            cyc++;
        end
        check("scan_latency", 32'(cyc), 32'd25);
        sb_check(32'(res_pattern_o));
    endtask

    typedef struct {
        int         h;
        int         v;
        logic [5:0] exp;
    } pt_t;

    pt_t pts[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        n_checks    = 0;
        n_errors    = 0;
        pat_mode    = 1'b0;
        rst_i       = 1'b1;
        hcnt_i      = 10'd5;
        vcnt_i      = 10'd5;
        res_ready_i = 1'b0;

        pts[0] = '{h: 60,  v: 160, exp: {1'b1, 3'd0, 2'd0}};
        pts[1] = '{h: 60,  v: 150, exp: {1'b0, 3'd0, 2'd0}};
        pts[2] = '{h: 100, v: 260, exp: {1'b1, 3'd0, 2'd3}};
        pts[3] = '{h: 130, v: 200, exp: {1'b0, 3'd0, 2'd3}};
        pts[4] = '{h: 125, v: 200, exp: {1'b0, 3'd0, 2'd3}};
        pts[5] = '{h: 440, v: 170, exp: {1'b1, 3'd4, 2'd0}};
        pts[6] = '{h: 400, v: 240, exp: {1'b1, 3'd3, 2'd3}};
        pts[7] = '{h: 520, v: 300, exp: {1'b1, 3'd5, 2'd2}};

        repeat (2) @(negedge clk_i);
        check("reset_ctl", ctl_vec(), 32'd0);
        check("reset_pattern", 32'(res_pattern_o), 32'd0);

        // Enter ACCUM, then hit it with an asynchronous reset.
        rst_i = 1'b0;
        step(0, 0);
        step(100, 200);
        check("clr_first", 32'(acc_clr_o), 32'd1);
        step(100, 200);
        check("clr_once", 32'(acc_clr_o), 32'd0);
        step(100, 200);
        check("pre_rst_acc", acc_vec(), 32'({1'b1, 3'd0, 2'd1}));
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_ctl", ctl_vec(), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        step(0, 0);
        step(1, 0);
        check("clr_after_rst", 32'(acc_clr_o), 32'd1);
        check("busy_clear", 32'(busy_o), 32'd1);
        step(2, 0);
        check("clr_after_rst_len", 32'(acc_clr_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            step(pts[i].h, pts[i].v);
            if (i > 0) sb_check(acc_vec());
            sb_push($sformatf("acc_pt%0d", i), 32'(pts[i].exp));
        end
        step(520, 301);
        sb_check(acc_vec());
        run_scan(24'h555555);

`ifndef SEG_AUTO_ACK_EN
        repeat (3) step(7, 400);
        check("hold_valid", 32'(res_valid_o), 32'd1);
        step(0, 0);
        step(1, 0);
        check("present_ovr", 32'(overrun_o), 32'd1);
        check("present_ovr_pat", 32'(res_pattern_o), 32'h555555);
        check("present_ovr_valid", 32'(res_valid_o), 32'd1);
        step(2, 0);
        check("present_ovr_once", 32'(overrun_o), 32'd0);
        check("present_no_clr", 32'(acc_clr_o), 32'd0);
        res_ready_i = 1'b1;
        step(3, 0);
        check("xfer_valid_low", 32'(res_valid_o), 32'd0);
        check("xfer_idle", 32'(busy_o), 32'd0);
        res_ready_i = 1'b0;
`else
        step(7, 302);
        check("auto_pulse", 32'(res_valid_o), 32'd0);
        check("auto_idle", 32'(busy_o), 32'd0);
        step(0, 0);
        step(1, 0);
        check("auto_no_ovr", 32'(overrun_o), 32'd0);
        check("auto_clr", 32'(acc_clr_o), 32'd1);
        step(2, 0);
        step(520, 301);
        run_scan(24'h555555);
        step(7, 302);
        check("auto_pulse2", 32'(res_valid_o), 32'd0);
        check("auto_no_ovr2", 32'(overrun_o), 32'd0);
`endif

        // Short frame: fs arrives mid-scan.
        step(0, 0);
        step(1, 0);
        check("frame2_clr", 32'(acc_clr_o), 32'd1);
        step(2, 0);
        step(520, 301);
        step(7, 302);
        cyc = 0;
        while (rd_sel_o != 5'd10 && cyc < 100) begin
            step(7, 302);
            cyc++;
        end
        check("short_rd_sel", 32'(rd_sel_o), 32'd10);
        hcnt_i = 10'd0;
        vcnt_i = 10'd0;
        step(1, 0);
        check("short_ovr", 32'(overrun_o), 32'd1);
        check("short_clr", 32'(acc_clr_o), 32'd1);
        check("short_valid", 32'(res_valid_o), 32'd0);
        check("short_pat", 32'(res_pattern_o), 32'h555555);
        step(2, 0);
        check("short_ovr_once", 32'(overrun_o), 32'd0);
        check("short_valid2", 32'(res_valid_o), 32'd0);

        // Full scan with ready already high and a different readback pattern.
        res_ready_i = 1'b1;
        pat_mode    = 1'b1;
        step(520, 301);
        run_scan(24'h000fff);
        step(7, 302);
        check("ready_early_done", 32'(res_valid_o), 32'd0);
        check("ready_early_idle", 32'(busy_o), 32'd0);
        check("ready_early_pat", 32'(res_pattern_o), 32'h000fff);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
